// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: checks that a 2-bit counter steps +1 (mod 4), pulses on each 3->0 wrap,
// and keeps saturating wrap and error tallies with an optional sticky fault state.
module count_wrap_monitor #(
  parameter int WRAP_W       = 8,
  parameter int ERR_W        = 4,
  parameter bit ALLOW_HOLD   = 1'b0,
  parameter bit STICKY_FAULT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cnt_in,
  input  logic              mon_en,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_sat,
  output logic              seq_err,
  output logic [ERR_W-1:0]  err_count,
  output logic              fault
);
  typedef enum logic [1:0] {IDLE, ARM, TRACK, FAULT} state_t;
  state_t            state_q, state_d;
  logic [1:0]        prev_q, prev_d, delta;
  logic              wrap_pulse_q, wrap_pulse_d, seq_err_q, seq_err_d;
  logic              wrap_sat_q, wrap_sat_d, legal;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_pulse_d = 1'b0;
    seq_err_d    = 1'b0;
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;
    wrap_sat_d   = wrap_sat_q;
    delta        = cnt_in - prev_q;
    legal        = (delta == 2'd1) || (ALLOW_HOLD && delta == 2'd0);
    if (clr) begin
      wrap_count_d = '0;
      err_count_d  = '0;
      wrap_sat_d   = 1'b0;
      state_d      = mon_en ? ARM : IDLE;
    end else if (!mon_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          prev_d  = cnt_in;
          state_d = TRACK;
        end
        TRACK: begin
          prev_d = cnt_in;
          if (legal) begin
            if (prev_q == 2'd3 && cnt_in == 2'd0) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count_q + WRAP_W'(wrap_count_q != {WRAP_W{1'b1}});
              wrap_sat_d   = wrap_sat_q | (wrap_count_d == {WRAP_W{1'b1}});
            end
          end else begin
            seq_err_d   = 1'b1;
            err_count_d = err_count_q + ERR_W'(err_count_q != {ERR_W{1'b1}});
            state_d     = STICKY_FAULT ? FAULT : ARM;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      wrap_pulse_q <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
      wrap_sat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wrap_pulse_q <= wrap_pulse_d;
      seq_err_q    <= seq_err_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
      wrap_sat_q   <= wrap_sat_d;
    end
  end
  assign wrap_pulse = wrap_pulse_q;
  assign seq_err    = seq_err_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;
  assign wrap_sat   = wrap_sat_q;
  assign fault      = (state_q == FAULT);
endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor: two monitor configurations driven in lockstep, directed steps then
// random counter traffic, all checked against a step-level behavioural model.
module tb_count_wrap_monitor;
  logic clk = 1'b0, rst_n = 1'b0, mon_en = 1'b0, clr = 1'b0;
  logic [1:0] cnt_in = 2'd0;
  logic       wp0, ws0, se0, f0, wp1, ws1, se1, f1;
  logic [7:0] wc0;
  logic [3:0] ec0;
  logic [1:0] wc1, ec1;
  int compared = 0, mismatched = 0;
  int m_st[2], m_prev[2], m_wc[2], m_ec[2], m_ws[2], m_wp[2], m_se[2];
  int p_hold[2]   = '{0, 1};
  int p_sticky[2] = '{1, 0};
  int p_wmax[2]   = '{255, 3};
  int p_emax[2]   = '{15, 3};
  localparam int S_IDLE = 0, S_ARM = 1, S_TRACK = 2, S_FAULT = 3;

  always #5 clk = ~clk;

  count_wrap_monitor d0 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .mon_en(mon_en), .clr(clr),
    .wrap_pulse(wp0), .wrap_count(wc0), .wrap_sat(ws0), .seq_err(se0), .err_count(ec0), .fault(f0)
  );
  count_wrap_monitor #(.WRAP_W(2), .ERR_W(2), .ALLOW_HOLD(1'b1), .STICKY_FAULT(1'b0)) d1 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .mon_en(mon_en), .clr(clr),
    .wrap_pulse(wp1), .wrap_count(wc1), .wrap_sat(ws1), .seq_err(se1), .err_count(ec1), .fault(f1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("d0.wrap_pulse", 32'(wp0), m_wp[0]);
    chk("d0.wrap_count", 32'(wc0), m_wc[0]);
    chk("d0.wrap_sat",   32'(ws0), m_ws[0]);
    chk("d0.seq_err",    32'(se0), m_se[0]);
    chk("d0.err_count",  32'(ec0), m_ec[0]);
    chk("d0.fault",      32'(f0),  32'(m_st[0] == S_FAULT));
    chk("d1.wrap_pulse", 32'(wp1), m_wp[1]);
    chk("d1.wrap_count", 32'(wc1), m_wc[1]);
    chk("d1.wrap_sat",   32'(ws1), m_ws[1]);
    chk("d1.seq_err",    32'(se1), m_se[1]);
    chk("d1.err_count",  32'(ec1), m_ec[1]);
    chk("d1.fault",      32'(f1),  32'(m_st[1] == S_FAULT));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_prev[i] = 0; m_wc[i] = 0; m_ec[i] = 0;
      m_ws[i] = 0; m_wp[i] = 0; m_se[i] = 0;
    end
  endtask

  // One clock edge of the reference behaviour for both configurations.
  task automatic model_step(input int c, input int en, input int cl);
    for (int i = 0; i < 2; i++) begin
      int d, old;
      m_wp[i] = 0; m_se[i] = 0;
      if (cl != 0) begin
        m_wc[i] = 0; m_ec[i] = 0; m_ws[i] = 0;
        m_st[i] = en != 0 ? S_ARM : S_IDLE;
      end else if (en == 0) begin
        m_st[i] = S_IDLE;
      end else if (m_st[i] == S_IDLE) begin
        m_st[i] = S_ARM;
      end else if (m_st[i] == S_ARM) begin
        m_prev[i] = c; m_st[i] = S_TRACK;
      end else if (m_st[i] == S_TRACK) begin
        old = m_prev[i];
        d = (c - old + 4) % 4;
        m_prev[i] = c;
        if (d == 1 || (d == 0 && p_hold[i] != 0)) begin
          if (old == 3 && c == 0) begin
            m_wp[i] = 1;
            if (m_wc[i] < p_wmax[i]) m_wc[i]++;
            if (m_wc[i] == p_wmax[i]) m_ws[i] = 1;
          end
        end else begin
          m_se[i] = 1;
          if (m_ec[i] < p_emax[i]) m_ec[i]++;
          m_st[i] = p_sticky[i] != 0 ? S_FAULT : S_ARM;
        end
      end
    end
  endtask

  task automatic cyc(input int c, input int en, input int cl);
    cnt_in = 2'(c); mon_en = en[0]; clr = cl[0];
    @(posedge clk);
    model_step(c, en, cl);
    #1 check_all();
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  task automatic seq(input int vals[$], input int en);
    foreach (vals[k]) cyc(vals[k], en, 0);
  endtask

  initial begin
    logic [1:0] c;
    model_reset();
    #1 check_all();
    #5 rst_n = 1'b1;
    // normal counting with leading IDLE and ARM samples
    seq('{0, 0, 1, 2, 3, 0, 1, 2, 3, 0}, 1);
    async_reset();
    // skip error then legal wraps that the sticky config ignores
    seq('{0, 0, 1, 3, 0, 1, 2, 3, 0}, 1);
    cyc(1, 1, 1);
    seq('{2, 3, 0, 1}, 1);
    // hold: error only where holding is illegal
    cyc(1, 1, 1);
    seq('{1, 1, 2, 3, 0}, 1);
    // enough wraps to saturate the narrow config
    cyc(0, 1, 1);
    for (int w = 0; w < 5; w++) seq('{0, 1, 2, 3}, 1);
    cyc(0, 1, 0);
    // clr on the same edge as a 3->0 step
    seq('{1, 2, 3}, 1);
    cyc(0, 1, 1);
    // resync on the non-sticky config, then drop enable mid-run
    cyc(0, 1, 1);
    seq('{0, 0, 2, 3, 0, 1, 2}, 1);
    seq('{3, 0, 1}, 0);
    seq('{2, 3}, 1);
    c = 2'd0;
    for (int n = 0; n < 800; n++) begin
      c = ($urandom_range(0, 99) < 85) ? c + 2'd1 : 2'($urandom_range(0, 3));
      cyc(int'(c), int'($urandom_range(0, 39) != 0), int'($urandom_range(0, 79) == 0));
      if ($urandom_range(0, 249) == 0) async_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
